door_sensor_decoder: RTL
========================

Name: door_sensor_decoder

Overview:
- Upstream stage of the room occupancy controller.
- Watches two infrared beams across the doorway: beam_a on the outer side and beam_b on the inner side.
- Decodes the order in which the beams break into single-cycle `in` (entry) and `out` (exit) pulses, which drive the controller's `in`/`out` inputs directly.
- Rejects aborted passages, simultaneous breaks and stalled passages, and flags them on `err`.

Parameters:
- DEB_CYCLES, 4: consecutive identical synchronized samples needed before a filtered beam level changes; legal range 1..15.
- TMO_CYCLES, 200: maximum cycles spent outside IDLE before a passage is aborted; must be < 2^TW.
- TW, 8: width of the timeout counter.

Ports:
- clk  input  1  system clock
- clr  input  1  reset, asynchronous, active-low
- beam_a  input  1  outer beam, 1 = interrupted, asynchronous to clk
- beam_b  input  1  inner beam, 1 = interrupted, asynchronous to clk
- in  output  1  one-cycle pulse, one person entered
- out  output  1  one-cycle pulse, one person left
- busy  output  1  high while the FSM is not in IDLE
- err  output  1  one-cycle pulse on timeout or simultaneous break

Behaviour:
- Reset (clr low, asynchronous): in=0, out=0, err=0, busy=0, FSM=IDLE, timer=0, synchronizers=0, filtered levels fa=fb=0, debounce counters=0.
- Sampling: each beam passes through a 2-flop synchronizer, then the debounce filter.
  - The filtered level takes the new value when DEB_CYCLES consecutive synchronized samples differ from the current filtered value.
  - Any sample equal to the current filtered value reloads the debounce counter to 0.
- FSM, evaluated on the filtered pair {fa,fb}:
  - IDLE: 10 -> A1; 01 -> B1; 11 -> JAM with err pulse; 00 stays.
  - A1 (outer broken): 11 -> A2; 00 -> IDLE (abort, no pulse, no err); 01 -> A3.
  - A2 (both, entering): 01 -> A3; 10 -> A1; 00 -> IDLE (abort).
  - A3 (inner only): 00 -> IDLE with in pulse; 11 -> A2; 10 -> A1.
  - B1, B2, B3 mirror A1, A2, A3 with the beams swapped; B3 -> IDLE on 00 produces the out pulse.
  - JAM: waits for 00, then returns to IDLE with no pulse.
- Timeout:
  - The timer clears in IDLE and increments every cycle in any other state except JAM.
  - When timer == TMO_CYCLES - 1, the next state is JAM and err pulses; this takes priority over the decode transition in the same cycle.
- Outputs:
  - in, out and err are registered and are never high together.
  - Each is high for exactly one cycle per event.
  - busy = (state != IDLE), registered with the state.
- Latency: a beam edge that stays stable reaches the filtered level 2 + DEB_CYCLES cycles after the edge. in/out is asserted on the cycle after the final 00 is seen by the FSM.
- Back-to-back passages: a new passage may start the cycle after in/out is pulsed. No passage is lost as long as each beam level holds for at least DEB_CYCLES samples.
- Reset mid-passage: the passage is discarded, with no pulse after clr is released.

Optional Feature:
- DOOR_DEBOUNCE_EN
- Defined: the debounce filter is instantiated as described above.
- Undefined: the filter is bypassed, so fa/fb equal the synchronizer outputs, DEB_CYCLES is ignored and latency becomes 2 cycles + 1.
- FSM and timeout behaviour are identical in both builds.

Decomposition:
- Package door_pkg:
  - state enum {IDLE, A1, A2, A3, B1, B2, B3, JAM}, 3-bit encoding
  - default constants for DEB_CYCLES and TMO_CYCLES
- Sub-module beam_debounce: one per beam, holding the synchronizer plus the filter. Parameter DEB_CYCLES; ports clk, clr, raw, filt.

Test Plan:
- Entry, DEB_CYCLES=4: beam_a=1 for 10 cycles, then both for 10, then beam_b only for 10, then 00 -> exactly one `in` pulse 7 cycles after the final release; out=0 and err=0 throughout.
- Exit, mirrored sequence -> one `out` pulse; busy high from B1 entry until the pulse cycle.
- Abort: beam_a=1 for 10 cycles, then 00 -> no in/out/err pulse, busy returns to 0.
- Glitch: a 2-cycle beam_a pulse -> filtered level never changes and there are no pulses. With DOOR_DEBOUNCE_EN undefined, the FSM reaches A1 and returns to IDLE with no pulse.
- Timeout, TMO_CYCLES=20: beam_a held at 1 -> err pulse 20 cycles after A1 entry, FSM in JAM. After release, a normal entry yields an `in` pulse.
- Simultaneous break while IDLE -> err pulse and JAM state. Separately, asserting clr low while in A3 -> all outputs 0 immediately, and no `in` pulse follows.

Source files
------------

// File: rtl/door_pkg.sv
// door_pkg: shared state encoding and default timing constants for the doorway beam decoder
package door_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        A1   = 3'd1,
        A2   = 3'd2,
        A3   = 3'd3,
        B1   = 3'd4,
        B2   = 3'd5,
        B3   = 3'd6,
        JAM  = 3'd7
    } state_t;

    localparam int DEB_CYCLES_DEF = 4;
    localparam int TMO_CYCLES_DEF = 200;

endpackage

// File: rtl/beam_debounce.sv
// beam_debounce: 2-flop synchronizer plus persistence filter (filter present only with DOOR_DEBOUNCE_EN)
module beam_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic raw,
    output logic filt
);

    if (DEB_CYCLES < 1 || DEB_CYCLES > 15) begin : g_bad_deb
        $error("DEB_CYCLES must be within 1..15");
    end

    logic [1:0] r_sync;

    // bring the asynchronous beam level into the clock domain
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) r_sync <= '0;
        else      r_sync <= {r_sync[0], raw};
    end

`ifdef DOOR_DEBOUNCE_EN
    logic [3:0] r_cnt;
    logic       r_filt;

    // adopt the new level only after DEB_CYCLES consecutive samples disagree with the current one
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (r_sync[1] == r_filt) begin
            r_cnt  <= '0;
        end else if (r_cnt == 4'(DEB_CYCLES - 1)) begin
            r_cnt  <= '0;
            r_filt <= r_sync[1];
        end else begin
            r_cnt  <= r_cnt + 4'd1;
        end
    end

    assign filt = r_filt;
`else
    assign filt = r_sync[1];
`endif

endmodule

// File: rtl/door_sensor_decoder.sv
// door_sensor_decoder: turns the beam break order into entry/exit pulses; DOOR_DEBOUNCE_EN enables the beam filters
module door_sensor_decoder
    import door_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int TMO_CYCLES = TMO_CYCLES_DEF,
    parameter int TW         = 8
) (
    input  logic clk,
    input  logic clr,
    input  logic beam_a,
    input  logic beam_b,
    output logic in,
    output logic out,
    output logic busy,
    output logic err
);

    if (TMO_CYCLES < 1 || TMO_CYCLES >= (1 << TW)) begin : g_bad_tmo
        $error("TMO_CYCLES must be within 1..2**TW-1");
    end

    logic          w_fa;
    logic          w_fb;
    logic [1:0]    w_ab;
    logic          w_tmo;
    logic          w_in;
    logic          w_out;
    logic          w_err;
    state_t        w_next;
    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic          r_in;
    logic          r_out;
    logic          r_err;
    logic          r_busy;

    beam_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
        .clk  (clk),
        .clr  (clr),
        .raw  (beam_a),
        .filt (w_fa)
    );

    beam_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
        .clk  (clk),
        .clr  (clr),
        .raw  (beam_b),
        .filt (w_fb)
    );

    assign w_ab  = {w_fa, w_fb};
    assign w_tmo = (r_state != IDLE) && (r_state != JAM) && (r_timer == TW'(TMO_CYCLES - 1));

    // next-state decode; a stalled passage goes to JAM ahead of any beam transition
    always_comb begin
        w_next = r_state;
        w_in   = 1'b0;
        w_out  = 1'b0;
        w_err  = 1'b0;
        if (w_tmo) begin
            w_next = JAM;
            w_err  = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_next = w_ab == 2'b10 ? A1 : w_ab == 2'b01 ? B1 : w_ab == 2'b11 ? JAM : IDLE;
                    w_err  = w_ab == 2'b11;
                end
                A1, A2, A3: begin
                    w_next = w_ab == 2'b10 ? A1 : w_ab == 2'b11 ? A2 : w_ab == 2'b01 ? A3 : IDLE;
                    w_in   = r_state == A3 && w_ab == 2'b00;
                end
                B1, B2, B3: begin
                    w_next = w_ab == 2'b01 ? B1 : w_ab == 2'b11 ? B2 : w_ab == 2'b10 ? B3 : IDLE;
                    w_out  = r_state == B3 && w_ab == 2'b00;
                end
                JAM:     w_next = w_ab == 2'b00 ? IDLE : JAM;
                default: w_next = IDLE;
            endcase
        end
    end

    // state, passage timer and registered pulse outputs
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_in    <= 1'b0;
            r_out   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_timer <= r_state == IDLE ? '0 : r_state == JAM ? r_timer : r_timer + 1'b1;
            r_in    <= w_in;
            r_out   <= w_out;
            r_err   <= w_err;
            r_busy  <= w_next != IDLE;
        end
    end

    assign in   = r_in;
    assign out  = r_out;
    assign err  = r_err;
    assign busy = r_busy;

endmodule
